// File: rtl/scan_sequencer.sv
// Raster frame-scan controller: walks an external 4-bit pixel counter and an
// internal line counter, fetching each pixel from memory and handing it to the serializer.
module scan_sequencer #(
   parameter int unsigned PX_PER_LINE = 16,
   parameter int unsigned LINES       = 8,
   parameter int unsigned LINE_W      = 3,
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned PIX_W       = 8
) (
   input  logic              clock,
   input  logic              ResetN,
   input  logic              Start,
   input  logic              Stop,
   input  logic [3:0]        PxCount,
   output logic              ResetPx,
   output logic              IncPx,
   output logic              MemReq,
   output logic [ADDR_W-1:0] MemAddr,
   input  logic              MemAck,
   input  logic [PIX_W-1:0]  MemData,
   output logic              PixValid,
   output logic [PIX_W-1:0]  PixData,
   input  logic              PixReady,
   output logic [LINE_W-1:0] LineOut,
   output logic              Busy,
   output logic              FrameDone
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_FETCH,
      S_SEND,
      S_LINE_END,
      S_DONE
   } state_e;

   localparam logic [3:0]        LAST_PX   = 4'(PX_PER_LINE - 1);
   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

   state_e              state_q, state_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [PIX_W-1:0]    pix_data_q, pix_data_d;

   logic                in_frame;
   logic                abort;
   logic                start_ok;
   logic                px_accept;
   logic                last_px;
   logic                last_line;

   always_comb begin
      in_frame  = (state_q == S_FETCH) || (state_q == S_SEND) ||
                  (state_q == S_LINE_END) || (state_q == S_DONE);
      abort     = Stop && in_frame;
      start_ok  = (state_q == S_IDLE) && Start && !Stop;
      px_accept = (state_q == S_SEND) && PixReady && !Stop;
      last_px   = (PxCount == LAST_PX);
      last_line = (line_q == LAST_LINE);
   end

   always_ff @(posedge clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= S_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Stop overrides every in-frame transition, including a coincident handshake.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_INIT:     state_d = S_IDLE;
         S_IDLE:     if (start_ok) state_d = S_FETCH;
         S_FETCH:    if (MemAck) state_d = S_SEND;
         S_SEND:     if (PixReady) state_d = last_px ? S_LINE_END : S_FETCH;
         S_LINE_END: state_d = last_line ? S_DONE : S_FETCH;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_INIT;
      endcase
      if (abort) state_d = S_IDLE;
   end

   always_comb begin
      ResetPx   = 1'b0;
      IncPx     = 1'b0;
      MemReq    = 1'b0;
      PixValid  = 1'b0;
      Busy      = in_frame;
      FrameDone = 1'b0;
      unique case (state_q)
         S_INIT:     ResetPx = 1'b1;
         S_IDLE:     ResetPx = start_ok;
         S_FETCH:    MemReq = 1'b1;
         S_SEND: begin
            PixValid = 1'b1;
            if (px_accept) begin
               ResetPx = last_px;
               IncPx   = !last_px;
            end
         end
         S_LINE_END: ResetPx = 1'b0;
         S_DONE:     FrameDone = !Stop;
         default:    ResetPx = 1'b1;
      endcase
      if (abort) begin
         ResetPx = 1'b1;
         IncPx   = 1'b0;
      end
   end

   always_comb begin
      line_d = line_q;
      if (start_ok) begin
         line_d = '0;
      end else if ((state_q == S_LINE_END) && !Stop && !last_line) begin
         line_d = line_q + LINE_W'(1);
      end
   end

   always_comb begin
      pix_data_d = pix_data_q;
      if ((state_q == S_FETCH) && MemAck && !Stop) begin
         pix_data_d = MemData;
      end
   end

   always_ff @(posedge clock or negedge ResetN) begin
      if (!ResetN) begin
         line_q     <= '0;
         pix_data_q <= '0;
      end else begin
         line_q     <= line_d;
         pix_data_q <= pix_data_d;
      end
   end

   always_comb begin
      MemAddr = ADDR_W'(line_q) * ADDR_W'(PX_PER_LINE) + ADDR_W'(PxCount);
   end

   assign PixData = pix_data_q;
   assign LineOut = line_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: a cycle table for the control corners plus
// full-frame, stall, ack-delay and abort sequences against a behavioural pixel counter.
module tb_scan_sequencer;

   localparam int unsigned PXL = 16;
   localparam int unsigned LN  = 8;
   localparam int unsigned LW  = 3;
   localparam int unsigned AW  = 7;
   localparam int unsigned PW  = 8;

   logic          clock = 1'b0;
   logic          ResetN = 1'b0;
   logic          Start = 1'b0;
   logic          Stop = 1'b0;
   logic [3:0]    PxCount;
   logic          ResetPx;
   logic          IncPx;
   logic          MemReq;
   logic [AW-1:0] MemAddr;
   logic          MemAck = 1'b0;
   logic [PW-1:0] MemData = '0;
   logic          PixValid;
   logic [PW-1:0] PixData;
   logic          PixReady = 1'b0;
   logic [LW-1:0] LineOut;
   logic          Busy;
   logic          FrameDone;

   int checks = 0;
   int failures = 0;

   scan_sequencer #(
      .PX_PER_LINE(PXL),
      .LINES(LN),
      .LINE_W(LW),
      .ADDR_W(AW),
      .PIX_W(PW)
   ) dut (
      .clock(clock),
      .ResetN(ResetN),
      .Start(Start),
      .Stop(Stop),
      .PxCount(PxCount),
      .ResetPx(ResetPx),
      .IncPx(IncPx),
      .MemReq(MemReq),
      .MemAddr(MemAddr),
      .MemAck(MemAck),
      .MemData(MemData),
      .PixValid(PixValid),
      .PixData(PixData),
      .PixReady(PixReady),
      .LineOut(LineOut),
      .Busy(Busy),
      .FrameDone(FrameDone)
   );

   always #5 clock = ~clock;

   // External synchronous pixel counter driven by the DUT's ResetPx/IncPx.
   always_ff @(posedge clock or negedge ResetN) begin
      if (!ResetN)      PxCount <= '0;
      else if (ResetPx) PxCount <= '0;
      else if (IncPx)   PxCount <= PxCount + 4'd1;
   end

   typedef struct {
      logic       start;
      logic       stop;
      logic       ack;
      logic       rdy;
      logic [7:0] data;
      logic       rpx;
      logic       inc;
      logic       req;
      logic [6:0] addr;
      logic       pv;
      logic [7:0] pd;
      logic       busy;
      logic       fd;
      logic [2:0] line;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] observed();
      return {ResetPx, IncPx, MemReq, MemAddr, PixValid, PixData, Busy, FrameDone, LineOut};
   endfunction

   function automatic logic [23:0] expected(input vec_t v);
      return {v.rpx, v.inc, v.req, v.addr, v.pv, v.pd, v.busy, v.fd, v.line};
   endfunction

   initial begin
      int  exp_idx;
      int  inc_cnt;
      int  conflicts;
      int  done_cycle;
      int  stall;
      int  ackwait;
      logic stopped;
      logic fd_seen;
      logic stall_now;
      logic wait_now;

      //                start stop  ack   rdy   data    rpx   inc   req   addr   pv    pd      busy  fd    line
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'd0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 7'd0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 8'hA5, 1'b1, 1'b0, 3'd0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1, 8'hA5, 1'b1, 1'b0, 3'd0};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 7'd1, 1'b0, 8'hA5, 1'b1, 1'b0, 3'd0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 7'd1, 1'b1, 8'h3C, 1'b1, 1'b0, 3'd0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 8'h3C, 1'b0, 1'b0, 3'd0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 8'h3C, 1'b0, 1'b0, 3'd0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 8'h3C, 1'b0, 1'b0, 3'd0};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b1, 7'd0, 1'b0, 8'h3C, 1'b1, 1'b0, 3'd0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 8'h3C, 1'b0, 1'b0, 3'd0};

      // Reset held for three cycles, then the INIT cycle after release.
      for (int i = 0; i < 3; i++) begin
         @(negedge clock); #1;
         chk("reset_outputs", 32'(observed()), 32'(24'h800000));
      end
      @(negedge clock);
      ResetN = 1'b1;
      #1;
      chk("init_after_release", 32'(observed()), 32'(24'h800000));

      for (int i = 0; i < 13; i++) begin
         @(negedge clock);
         Start    = tbl[i].start;
         Stop     = tbl[i].stop;
         MemAck   = tbl[i].ack;
         PixReady = tbl[i].rdy;
         MemData  = tbl[i].data;
         #1;
         chk($sformatf("table_row_%0d", i), 32'(observed()), 32'(expected(tbl[i])));
      end

      // Zero-wait frame with data = address.
      @(negedge clock);
      Start = 1'b1; Stop = 1'b0; MemAck = 1'b1; PixReady = 1'b1;
      exp_idx = 0; inc_cnt = 0; conflicts = 0; done_cycle = -1;
      for (int n = 1; n <= 400 && done_cycle < 0; n++) begin
         @(negedge clock);
         Start = 1'b0;
         #1;
         MemData = PW'(MemAddr);
         if (ResetPx && IncPx) conflicts++;
         if (IncPx) inc_cnt++;
         if (PixValid && PixReady) begin
            chk("frame_pixel_order", 32'(PixData), 32'(exp_idx[7:0]));
            exp_idx++;
         end
         if (FrameDone) done_cycle = n;
      end
      chk("frame_done_cycle", 32'(done_cycle), 32'(265));
      chk("frame_pixel_total", 32'(exp_idx), 32'(128));
      chk("frame_incpx_total", 32'(inc_cnt), 32'(120));
      chk("rstpx_incpx_exclusive", 32'(conflicts), 32'(0));
      @(negedge clock);
      MemAck = 1'b0; PixReady = 1'b0;
      #1;
      chk("post_frame_busy", 32'(Busy), 32'(0));
      chk("post_frame_memreq", 32'(MemReq), 32'(0));
      chk("post_frame_line_held", 32'(LineOut), 32'(7));

      // Frame with a ready stall at pixel 3, ack delay at address 20, Stop at line 2 pixel 7.
      @(negedge clock);
      Start = 1'b1;
      exp_idx = 0; stall = 0; ackwait = 0; stopped = 1'b0; fd_seen = 1'b0;
      for (int n = 1; n <= 400 && !stopped; n++) begin
         @(negedge clock); #1;
         Start = 1'b0; Stop = 1'b0; MemAck = 1'b0; PixReady = 1'b0;
         stall_now = 1'b0; wait_now = 1'b0;
         if (MemReq) begin
            MemData = PW'(MemAddr);
            if ((MemAddr == 7'd20 || ackwait > 0) && ackwait < 4) begin
               wait_now = 1'b1;
               ackwait++;
               chk("ack_wait_addr", 32'(MemAddr), 32'(20));
               chk("ack_wait_no_valid", 32'(PixValid), 32'(0));
            end else begin
               MemAck = 1'b1;
            end
         end
         if (PixValid) begin
            if ((PixData == 8'd3 || stall > 0) && stall < 5) begin
               stall_now = 1'b1;
               stall++;
               chk("stall_data_held", 32'(PixData), 32'(3));
            end else if (PixData == 8'd39) begin
               Stop = 1'b1; PixReady = 1'b1; stopped = 1'b1;
            end else begin
               PixReady = 1'b1;
            end
         end
         #1;
         if (stall_now) begin
            chk("stall_no_incpx", 32'(IncPx), 32'(0));
            chk("stall_no_memreq", 32'(MemReq), 32'(0));
         end
         if (wait_now) chk("ack_wait_memreq", 32'(MemReq), 32'(1));
         if (stopped) begin
            chk("stop_resetpx", 32'(ResetPx), 32'(1));
            chk("stop_no_incpx", 32'(IncPx), 32'(0));
         end
         if (PixValid && PixReady && !Stop) begin
            chk("stall_frame_pixel_order", 32'(PixData), 32'(exp_idx[7:0]));
            exp_idx++;
         end
         if (FrameDone) fd_seen = 1'b1;
      end
      chk("stop_reached", 32'(stopped), 32'(1));
      chk("stall_cycles", 32'(stall), 32'(5));
      chk("ack_wait_cycles", 32'(ackwait), 32'(4));
      chk("pixels_before_stop", 32'(exp_idx), 32'(39));

      @(negedge clock);
      Stop = 1'b0; MemAck = 1'b0; PixReady = 1'b0;
      #1;
      if (FrameDone) fd_seen = 1'b1;
      chk("abort_no_framedone", 32'(fd_seen), 32'(0));
      chk("abort_idle_busy", 32'(Busy), 32'(0));
      chk("abort_idle_memreq", 32'(MemReq), 32'(0));
      chk("abort_idle_resetpx", 32'(ResetPx), 32'(0));
      chk("abort_line_held", 32'(LineOut), 32'(2));
      Start = 1'b1;
      #1;
      chk("restart_resetpx", 32'(ResetPx), 32'(1));
      @(negedge clock);
      Start = 1'b0;
      #1;
      chk("restart_memreq", 32'(MemReq), 32'(1));
      chk("restart_addr", 32'(MemAddr), 32'(0));
      chk("restart_line", 32'(LineOut), 32'(0));
      Stop = 1'b1;
      @(negedge clock);
      Stop = 1'b0;
      #1;
      chk("final_idle", 32'(Busy), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
